// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: operation codes and FSM states
// shared by the ALU control decoder and alu_exec.
package alu_exec_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BNE = 4'b0011;
  localparam logic [3:0] OP_BLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU with branch compare
// and an iterative one-bit-per-cycle SLL.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal
);

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shl1;
  logic [WIDTH-1:0] alu_res;
  logic             alu_taken;
  logic             alu_ill;
  logic             accept;
  logic             is_and, is_or, is_add;
  logic             is_sub, is_bne, is_blt;
  logic             is_sll;

  assign op_ready  = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign accept    = op_valid & op_ready;
  assign shamt     = b[SHW-1:0];
  assign diff      = a - b;
  assign shl1      = result << 1;

  assign is_and = (Operation == OP_AND);
  assign is_or  = (Operation == OP_OR);
  assign is_add = (Operation == OP_ADD);
  assign is_sub = (Operation == OP_SUB);
  assign is_bne = (Operation == OP_BNE);
  assign is_blt = (Operation == OP_BLT);
  assign is_sll = (Operation == OP_SLL);

  // Single-cycle result and branch decision for the live request
  always_comb begin
    alu_res   = '0;
    alu_taken = 1'b0;
    alu_ill   = 1'b0;
    unique case (1'b1)
      is_and: alu_res = a & b;
      is_or:  alu_res = a | b;
      is_add: alu_res = a + b;
      is_sub: begin
        alu_res   = diff;
        alu_taken = (a == b);
      end
      is_bne: begin
        alu_res   = diff;
        alu_taken = (a != b);
      end
      is_blt: begin
        alu_res   = diff;
        alu_taken = ($signed(a) < $signed(b));
      end
      is_sll: alu_res = a << shamt;
      default: alu_ill = 1'b1;
    endcase
  end

  // Control FSM; result doubles as the shift working register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_sll && shamt != '0) begin
              state        <= S_SHIFT;
              cnt          <= shamt;
              result       <= a;
              zero         <= 1'b0;
              branch_taken <= 1'b0;
              illegal      <= 1'b0;
            end else begin
              state        <= S_DONE;
              result       <= alu_res;
              zero         <= (alu_res == '0);
              branch_taken <= alu_taken;
              illegal      <= alu_ill;
            end
          end
        end
        S_SHIFT: begin
          result <= shl1;
          cnt    <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state <= S_DONE;
            zero  <= (shl1 == '0);
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: randomized self-checking bench
// with a behavioural ALU reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  Operation = 4'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] result;
  logic        zero;
  logic        branch_taken;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec #(.WIDTH(64), .SHW(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .Operation(Operation), .a(a), .b(b),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .zero(zero),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [3:0]  op,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic [63:0] r,
    output logic        z,
    output logic        t,
    output logic        il,
    output int          lat
  );
    t = 1'b0; il = 1'b0; lat = 1;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: begin r = x - y; t = (x == y); end
      4'b0011: begin r = x - y; t = (x != y); end
      4'b0111: begin
        r = x - y;
        t = ($signed(x) < $signed(y));
      end
      4'b0100: begin
        r   = x * (64'd1 << y[5:0]);
        lat = int'(y[5:0]) + 1;
      end
      default: begin r = '0; il = 1'b1; end
    endcase
    z = (r == 64'd0);
  endfunction

  task automatic do_op(
    input  logic [3:0]  op,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic [63:0] r,
    output logic        z,
    output logic        t,
    output logic        il,
    output int          lat
  );
    @(negedge clk);
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL op_ready_before_issue got=%b want=1", op_ready);
    end
    Operation = op; a = x; b = y; op_valid = 1'b1;
    @(posedge clk); #1;
    Operation = 4'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    lat = 1;
    while (res_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; t = branch_taken; il = illegal;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    op_valid  = 1'b0;
  endtask

  task automatic run_check(
    input string       name,
    input logic [3:0]  op,
    input logic [63:0] x,
    input logic [63:0] y
  );
    logic [63:0] r, er;
    logic z, t, il, ez, et, eil;
    int lat, elat;
    model(op, x, y, er, ez, et, eil, elat);
    do_op(op, x, y, r, z, t, il, lat);
    n_tests++;
    if ({r, z, t, il} !== {er, ez, et, eil} || lat != elat) begin
      n_fail++;
      $display("FAIL %s op=%b a=%h b=%h got r=%h z=%b t=%b il=%b lat=%0d want r=%h z=%b t=%b il=%b lat=%0d",
               name, op, x, y, r, z, t, il, lat, er, ez, et, eil, elat);
    end
    consume();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_tests++;
    if ({op_ready, res_valid, result, zero, branch_taken, illegal}
        !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b r=%h z=%b t=%b il=%b want 1 0 0 0 0 0",
               op_ready, res_valid, result, zero, branch_taken, illegal);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_check("add_5_7", 4'b0010, 64'd5, 64'd7);
    run_check("beq_m3_4", 4'b0110, -64'sd3, 64'd4);
    run_check("bne_m3_4", 4'b0011, -64'sd3, 64'd4);
    run_check("blt_m3_4", 4'b0111, -64'sd3, 64'd4);
    run_check("and", 4'b0000, 64'hF0F0, 64'h0FF0);
    run_check("or", 4'b0001, 64'hF000, 64'h000F);
    run_check("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
  endtask

  task automatic test_fixed_values();
    logic [63:0] r;
    logic z, t, il;
    int lat;
    do_op(4'b0010, 64'd5, 64'd7, r, z, t, il, lat);
    n_tests++;
    if (r !== 64'd12 || z !== 1'b0 || t !== 1'b0 || lat != 1) begin
      n_fail++;
      $display("FAIL add_const got r=%0d z=%b t=%b lat=%0d want 12 0 0 1", r, z, t, lat);
    end
    consume();
    do_op(4'b0111, -64'sd3, 64'd4, r, z, t, il, lat);
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFF9 || t !== 1'b1) begin
      n_fail++;
      $display("FAIL blt_const got r=%h t=%b want fffffffffffffff9 1", r, t);
    end
    consume();
    do_op(4'b0100, 64'd1, 64'd5, r, z, t, il, lat);
    n_tests++;
    if (r !== 64'd32 || lat != 6) begin
      n_fail++;
      $display("FAIL sll5_const got r=%0d lat=%0d want 32 6", r, lat);
    end
    consume();
  endtask

  task automatic test_sll();
    run_check("sll_b5", 4'b0100, 64'd1, 64'd5);
    run_check("sll_b0", 4'b0100, 64'd1, 64'd0);
    run_check("sll_b63", 4'b0100, 64'd1, 64'd63);
    run_check("sll_hi_bits", 4'b0100, 64'h3, 64'hFFC1);
    run_check("sll_to_zero", 4'b0100, 64'h2, 64'd63);
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    logic z, t, il;
    int lat;
    do_op(4'b0110, 64'd9, 64'd9, r, z, t, il, lat);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({res_valid, op_ready, result, zero, branch_taken, illegal}
          !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure cyc=%0d got vld=%b rdy=%b r=%h z=%b t=%b il=%b want 1 0 0 1 1 0",
                 i, res_valid, op_ready, result, zero, branch_taken, illegal);
      end
    end
    consume();
    n_tests++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_consume got rdy=%b vld=%b want 1 0", op_ready, res_valid);
    end
  endtask

  task automatic test_illegal();
    run_check("illegal_1111", 4'b1111, 64'd12, 64'd34);
    run_check("illegal_0101", 4'b0101, 64'd0, 64'd0);
    run_check("illegal_1000", 4'b1000, 64'hAA, 64'h55);
  endtask

  task automatic test_reset_mid_sll();
    int seen;
    @(negedge clk);
    Operation = 4'b0100; a = 64'd1; b = 64'd40; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL mid_sll_reset got rdy=%b vld=%b r=%h want 1 0 0",
               op_ready, res_valid, result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL aborted_sll got valid_cycles=%0d rdy=%b want 0 1", seen, op_ready);
    end
    run_check("post_reset_add", 4'b0010, 64'd100, 64'd23);
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [63:0] x, y;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0011; ops[5] = 4'b0111;
    ops[6] = 4'b0100; ops[7] = 4'b0100;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = 4'($urandom);
      else op = ops[$urandom_range(0, 7)];
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) y = x;
      if ($urandom_range(0, 5) == 0) x = 64'd0;
      run_check("random", op, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fixed_values();
    test_sll();
    test_backpressure();
    test_illegal();
    test_reset_mid_sll();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter SHW, default 6, shift-amount width, equal to log2(WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  request present on Operation, a and b.
REQ-006 op_ready  output  1  unit can accept a request this cycle.
REQ-007 Operation  input  4  operation code, in the same encoding the ALU control decoder produces.
REQ-008 a  input  WIDTH  operand A (rs1).
REQ-009 b  input  WIDTH  operand B (rs2 or immediate); b[SHW-1:0] is the shift amount for SLL.
REQ-010 res_valid  output  1  result bundle valid.
REQ-011 res_ready  input  1  consumer accepts the result bundle.
REQ-012 result  output  WIDTH  computed value.
REQ-013 zero  output  1  high when result equals 0.
REQ-014 branch_taken  output  1  branch condition met; 0 for non-branch ops.
REQ-015 illegal  output  1  Operation was not a supported code.

Function
REQ-016 Supported codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB/beq (taken when a==b); 0011 bne (result a-b, taken when a!=b); 0111 blt (result a-b, taken when signed a<b); 0100 SLL (a << b[SHW-1:0]).
REQ-017 ADD and SUB arithmetic is modulo 2^WIDTH; carry and overflow are discarded.
REQ-018 FSM states: IDLE, SHIFT, DONE.
REQ-019 op_ready is 1 only in IDLE.
REQ-020 A request is accepted on a clk edge where op_valid and op_ready are both 1; operands and code are registered at that edge.
REQ-021 IDLE to DONE occurs on acceptance of a non-SLL op, or an SLL with shift amount 0; res_valid is 1 the cycle after acceptance (latency 1).
REQ-022 IDLE to SHIFT occurs on acceptance of an SLL with shift amount n>0.
REQ-023 SHIFT shifts the working register left by 1 and decrements the counter each cycle; the transition to DONE occurs when the counter reaches 0, so res_valid rises n+1 cycles after acceptance.
REQ-024 An unsupported code goes to DONE with result 0, zero 1, branch_taken 0 and illegal 1.
REQ-025 DONE holds result, zero, branch_taken and illegal stable while res_valid=1 and res_ready=0.
REQ-026 DONE to IDLE occurs on a clk edge with res_ready=1; there is no same-cycle re-acceptance, so the minimum request spacing is 2 cycles.
REQ-027 op_valid is ignored outside IDLE; inputs changing during SHIFT or DONE do not affect the result in flight.
REQ-028 res_valid is 0 in IDLE and SHIFT.
REQ-029 zero and branch_taken derive from the registered result and operands, never from live inputs.

Reset
REQ-030 reset_n=0 forces IDLE immediately, independent of clk.
REQ-031 During reset: op_ready 1 after the FSM is in IDLE, res_valid 0, result 0, zero 0, branch_taken 0, illegal 0, shift counter 0.
REQ-032 Reset asserted in SHIFT or DONE aborts the operation; no result is ever presented for it.
REQ-033 After reset_n deasserts, the first clk edge may accept a request.

Structure
REQ-034 Package alu_exec_pkg holds the seven operation-code constants and the FSM state enum; ALU_Control and alu_exec both use these constants.
REQ-035 No sub-module; the iterative shifter and compare logic are implemented inline in alu_exec.

Verification
REQ-036 ADD: a=5, b=7, op 0010 -> res_valid 1 cycle later, result 12, zero 0, branch_taken 0.
REQ-037 beq/bne/blt: a=-3, b=4 -> 0110 taken 0; 0011 taken 1; 0111 taken 1; each with result 0xFFFF_FFFF_FFFF_FFF9.
REQ-038 SLL: a=1, b=5 -> res_valid exactly 6 cycles after acceptance, result 32; b=0 -> latency 1, result 1; b=63 -> result 0x8000_0000_0000_0000.
REQ-039 Backpressure: hold res_ready=0 for 4 cycles after SUB a=9, b=9 -> bundle stable (result 0, zero 1, taken 1), op_ready 0 throughout.
REQ-040 Illegal op 1111 -> illegal 1, result 0; reset_n pulsed low mid-SLL (b=40) -> res_valid never rises, op_ready 1 after release.
